// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit A+B+Cin computed DIGIT bits per clock with a start/busy/done handshake.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN, which adds the 'sub' input.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;

  logic             sub_w;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] acc_shift;
  logic             last;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  // Subtraction is A + ~B + ~Cin, so Cin acts as an active-high borrow-in.
  assign b_eff   = sub_w ? ~B : B;
  assign cin_eff = Cin ^ sub_w;

  assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  // New digit enters from the MSB side; whole-vector shift keeps DIGIT==WIDTH legal.
  assign acc_shift = WIDTH'({dsum[DIGIT-1:0], acc_q} >> DIGIT);
  assign last      = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    v_d     = v_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    busy    = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = b_eff;
          carry_d = cin_eff;
          cnt_d   = '0;
          acc_d   = '0;
          a_msb_d = A[WIDTH-1];
          b_msb_d = b_eff[WIDTH-1];
        end
      end
      RUN: begin
        busy    = 1'b1;
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dsum[DIGIT];
        acc_d   = acc_shift;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          s_d     = acc_shift;
          cout_d  = dsum[DIGIT];
          v_d     = (a_msb_q == b_msb_q) && (acc_shift[WIDTH-1] != a_msb_q);
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = b_eff;
          carry_d = cin_eff;
          cnt_d   = '0;
          acc_d   = '0;
          a_msb_d = A[WIDTH-1];
          b_msb_d = b_eff[WIDTH-1];
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign V    = v_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: DIGIT=1, 4 and 8 instances sharing clock and reset.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic [2:0] start_s, cin_s, busy_s, done_s, cout_s, v_s;
  logic [7:0] a_s [3];
  logic [7:0] b_s [3];
  logic [7:0] s_s [3];
  logic [7:0] last_s [3];
`ifdef SERIAL_ADDER_SUB_EN
  logic [2:0] sub_s;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_s[0]),
`endif
    .start(start_s[0]), .A(a_s[0]), .B(b_s[0]), .Cin(cin_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .S(s_s[0]), .Cout(cout_s[0]), .V(v_s[0])
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_s[1]),
`endif
    .start(start_s[1]), .A(a_s[1]), .B(b_s[1]), .Cin(cin_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .S(s_s[1]), .Cout(cout_s[1]), .V(v_s[1])
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_s[2]),
`endif
    .start(start_s[2]), .A(a_s[2]), .B(b_s[2]), .Cin(cin_s[2]),
    .busy(busy_s[2]), .done(done_s[2]), .S(s_s[2]), .Cout(cout_s[2]), .V(v_s[2])
  );

  // One operation on instance d with n digit cycles; checks latency, holding and results.
  task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] es, input logic ec, input logic ev, input int n,
                        input string nm);
    @(negedge clk);
    start_s[d] = 1'b1; a_s[d] = a; b_s[d] = b; cin_s[d] = cin;
    @(negedge clk);
    start_s[d] = 1'b0; a_s[d] = ~a; b_s[d] = ~b; cin_s[d] = ~cin;
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (busy_s[d] !== 1'b1) begin
        n_fail++; $display("FAIL %s busy run%0d: got %b want 1", nm, i, busy_s[d]);
      end
      n_checks++;
      if (done_s[d] !== 1'b0) begin
        n_fail++; $display("FAIL %s early_done run%0d: got %b want 0", nm, i, done_s[d]);
      end
      n_checks++;
      if (s_s[d] !== last_s[d]) begin
        n_fail++; $display("FAIL %s S_hold run%0d: got %h want %h", nm, i, s_s[d], last_s[d]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done_s[d] !== 1'b1 || busy_s[d] !== 1'b0) begin
      n_fail++; $display("FAIL %s done/busy: got %b/%b want 1/0", nm, done_s[d], busy_s[d]);
    end
    n_checks++;
    if (s_s[d] !== es) begin
      n_fail++; $display("FAIL %s S: got %h want %h", nm, s_s[d], es);
    end
    n_checks++;
    if (cout_s[d] !== ec) begin
      n_fail++; $display("FAIL %s Cout: got %b want %b", nm, cout_s[d], ec);
    end
    n_checks++;
    if (v_s[d] !== ev) begin
      n_fail++; $display("FAIL %s V: got %b want %b", nm, v_s[d], ev);
    end
    last_s[d] = es;
    @(negedge clk);
    n_checks++;
    if (done_s[d] !== 1'b0 || s_s[d] !== es) begin
      n_fail++; $display("FAIL %s after_done: done=%b S=%h want 0 %h", nm, done_s[d], s_s[d], es);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_s = '0; cin_s = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub_s = '0;
`endif
    for (int d = 0; d < 3; d++) begin
      a_s[d] = '0; b_s[d] = '0; last_s[d] = '0;
    end
    #3;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (busy_s[d] !== 1'b0 || done_s[d] !== 1'b0 || s_s[d] !== 8'h00 ||
          cout_s[d] !== 1'b0 || v_s[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: busy=%b done=%b S=%h Cout=%b V=%b want all 0",
                 d, busy_s[d], done_s[d], s_s[d], cout_s[d], v_s[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_add();
    run_op(0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8, "add_zero");
    run_op(0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 8, "add_small");
  endtask

  task automatic test_carry_ripple();
    run_op(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8, "ripple_ff01");
    run_op(0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 8, "ripple_7f_cin");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start_s[0] = 1'b1; a_s[0] = 8'h12; b_s[0] = 8'h34; cin_s[0] = 1'b0;
    @(negedge clk);
    a_s[0] = 8'h11; b_s[0] = 8'h11;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (busy_s[0] !== 1'b1 || done_s[0] !== 1'b0 || s_s[0] !== last_s[0]) begin
        n_fail++;
        $display("FAIL hs_run1 cyc%0d: busy=%b done=%b S=%h want 1 0 %h",
                 i, busy_s[0], done_s[0], s_s[0], last_s[0]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done_s[0] !== 1'b1 || s_s[0] !== 8'h46 || cout_s[0] !== 1'b0 || v_s[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_first: done=%b S=%h C=%b V=%b want 1 46 0 0",
               done_s[0], s_s[0], cout_s[0], v_s[0]);
    end
    a_s[0] = 8'h03; b_s[0] = 8'h04; cin_s[0] = 1'b0;
    @(negedge clk);
    start_s[0] = 1'b0; a_s[0] = 8'hAA; b_s[0] = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (busy_s[0] !== 1'b1 || done_s[0] !== 1'b0 || s_s[0] !== 8'h46) begin
        n_fail++;
        $display("FAIL hs_run2 cyc%0d: busy=%b done=%b S=%h want 1 0 46",
                 i, busy_s[0], done_s[0], s_s[0]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done_s[0] !== 1'b1 || s_s[0] !== 8'h07 || cout_s[0] !== 1'b0 || v_s[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_second: done=%b S=%h C=%b V=%b want 1 07 0 0",
               done_s[0], s_s[0], cout_s[0], v_s[0]);
    end
    last_s[0] = 8'h07;
    @(negedge clk);
    n_checks++;
    if (done_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
      n_fail++; $display("FAIL hs_idle: done=%b busy=%b want 0 0", done_s[0], busy_s[0]);
    end
  endtask

  task automatic test_reset_mid_op();
    run_op(0, 8'hC0, 8'h90, 1'b0, 8'h50, 1'b1, 1'b1, 8, "pre_reset");
    @(negedge clk);
    start_s[0] = 1'b1; a_s[0] = 8'h55; b_s[0] = 8'h22; cin_s[0] = 1'b0;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy_s[0] !== 1'b0 || done_s[0] !== 1'b0 || s_s[0] !== 8'h00 ||
        cout_s[0] !== 1'b0 || v_s[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b done=%b S=%h C=%b V=%b want all 0",
               busy_s[0], done_s[0], s_s[0], cout_s[0], v_s[0]);
    end
    for (int d = 0; d < 3; d++) last_s[d] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (busy_s[0] !== 1'b0 || done_s[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset cyc%0d: busy=%b done=%b want 0 0", i, busy_s[0], done_s[0]);
      end
      @(negedge clk);
    end
    run_op(0, 8'h55, 8'h22, 1'b0, 8'h77, 1'b0, 1'b0, 8, "after_reset");
  endtask

  task automatic test_digit_widths();
    run_op(1, 8'h9C, 8'h87, 1'b1, 8'h24, 1'b1, 1'b1, 2, "d4_9c87");
    run_op(1, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 2, "d4_carry_mid");
    run_op(2, 8'h9C, 8'h87, 1'b1, 8'h24, 1'b1, 1'b1, 1, "d8_9c87");
    run_op(2, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1, "d8_ff01");
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    sub_s[0] = 1'b1;
    run_op(0, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, 8, "sub_0507");
    run_op(0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 8, "sub_8001");
    run_op(0, 8'h10, 8'h03, 1'b1, 8'h0C, 1'b1, 1'b0, 8, "sub_borrow_in");
    sub_s[0] = 1'b0;
    run_op(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8, "sub0_ff01");
    run_op(0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 8, "sub0_7f_cin");
  endtask
`endif

  initial begin
    test_reset();
    test_basic_add();
    test_carry_ripple();
    test_back_to_back();
    test_reset_mid_op();
    test_digit_widths();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
